// File: rtl/imm_gen_pkg.sv
// Shared types and RISC-V opcode constants for the decode-stage immediate generator.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_CSR  = 3'b101,
        IMM_AUTO = 3'b110,
        IMM_RSV  = 3'b111
    } imm_type_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    // SYSTEM splits on funct3[2]: the immediate CSR forms carry zimm, the rest use the I field.
    function automatic imm_type_e decode_opcode(input logic [31:0] instr);
        case (instr[6:0])
            OP_IMM, LOAD, JALR, OP_IMM32: return IMM_I;
            STORE:                        return IMM_S;
            BRANCH:                       return IMM_B;
            LUI, AUIPC:                   return IMM_U;
            JAL:                          return IMM_J;
            SYSTEM:                       return instr[14] ? IMM_CSR : IMM_I;
            default:                      return IMM_RSV;
        endcase
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: resolves the immediate type and builds the
// XLEN-wide immediate from a 32-bit instruction word.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      resolved_type,
    output logic            illegal
);

    imm_type_e   sel;
    logic [31:0] imm32;

    // Every format is formed at 32 bits first; widening to XLEN is one sign extension.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    always_comb begin
        sel = imm_type_e'(imm_type);
        if (sel == IMM_AUTO) begin
            sel = (AUTO_DECODE != 0) ? decode_opcode(instr) : IMM_RSV;
        end

        imm32   = '0;
        illegal = 1'b0;
        case (sel)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_CSR: imm32 = {27'b0, instr[19:15]};
            default: illegal = 1'b1;
        endcase

        imm           = sext32(imm32);
        resolved_type = illegal ? IMM_RSV : sel;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready on both sides and a two-entry
// skid buffer (output register plus skid register) for full-rate backpressure.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 8,
    parameter int AUTO_DECODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_in,
    input  logic [2:0]       imm_type_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_type_out,
    output logic             illegal_out,
    output logic [TAG_W-1:0] tag_out
);

    logic [XLEN-1:0]  ext_imm;
    logic [2:0]       ext_type;
    logic             ext_illegal;

    logic             sk_valid;
    logic [XLEN-1:0]  sk_imm;
    logic [2:0]       sk_type;
    logic             sk_illegal;
    logic [TAG_W-1:0] sk_tag;

    logic             accept;
    logic             or_free;

    imm_extract #(
        .XLEN        (XLEN),
        .AUTO_DECODE (AUTO_DECODE)
    ) u_extract (
        .instr         (instr_in),
        .imm_type      (imm_type_in),
        .imm           (ext_imm),
        .resolved_type (ext_type),
        .illegal       (ext_illegal)
    );

    // Ready comes straight from the skid flop, so out_ready never reaches in_ready combinationally.
    assign in_ready = !sk_valid;
    assign accept   = in_valid && in_ready;
    assign or_free  = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            imm_out      <= '0;
            imm_type_out <= '0;
            illegal_out  <= 1'b0;
            tag_out      <= '0;
            sk_valid     <= 1'b0;
            sk_imm       <= '0;
            sk_type      <= '0;
            sk_illegal   <= 1'b0;
            sk_tag       <= '0;
        end else if (or_free) begin
            // A parked skid entry is always older than anything arriving, so it goes first.
            if (sk_valid) begin
                out_valid    <= 1'b1;
                imm_out      <= sk_imm;
                imm_type_out <= sk_type;
                illegal_out  <= sk_illegal;
                tag_out      <= sk_tag;
                sk_valid     <= 1'b0;
            end else if (accept) begin
                out_valid    <= 1'b1;
                imm_out      <= ext_imm;
                imm_type_out <= ext_type;
                illegal_out  <= ext_illegal;
                tag_out      <= tag_in;
            end else begin
                out_valid    <= 1'b0;
            end
        end else if (accept) begin
            sk_valid   <= 1'b1;
            sk_imm     <= ext_imm;
            sk_type    <= ext_type;
            sk_illegal <= ext_illegal;
            sk_tag     <= tag_in;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32, XLEN=64 and AUTO_DECODE=0 instances
// share one stimulus stream; pipe behaviour is observed on the XLEN=32 instance.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr_in;
    logic [2:0]  imm_type_in;
    logic [7:0]  tag_in;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a;
    logic [2:0]  type_a;
    logic [7:0]  tag_a;

    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] imm_b;
    logic [2:0]  type_b;
    logic [7:0]  tag_b;

    logic        in_ready_c, out_valid_c, illegal_c;
    logic [31:0] imm_c;
    logic [2:0]  type_c;
    logic [7:0]  tag_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .AUTO_DECODE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr_in(instr_in), .imm_type_in(imm_type_in), .tag_in(tag_in),
        .out_valid(out_valid_a), .out_ready(out_ready), .imm_out(imm_a),
        .imm_type_out(type_a), .illegal_out(illegal_a), .tag_out(tag_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .AUTO_DECODE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr_in(instr_in), .imm_type_in(imm_type_in), .tag_in(tag_in),
        .out_valid(out_valid_b), .out_ready(out_ready), .imm_out(imm_b),
        .imm_type_out(type_b), .illegal_out(illegal_b), .tag_out(tag_b)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .AUTO_DECODE(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .instr_in(instr_in), .imm_type_in(imm_type_in), .tag_in(tag_in),
        .out_valid(out_valid_c), .out_ready(out_ready), .imm_out(imm_c),
        .imm_type_out(type_c), .illegal_out(illegal_c), .tag_out(tag_c)
    );

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // One instruction through an idle pipe: drive, see it one cycle later, then see it drain.
    task automatic applyStimulus(input string name, input logic [31:0] instr,
                                 input logic [2:0] typ, input logic [7:0] tag,
                                 input logic [31:0] exp32, input logic [63:0] exp64,
                                 input logic [2:0] exp_type, input logic exp_ill);
        @(negedge clk);
        in_valid    = 1'b1;
        instr_in    = instr;
        imm_type_in = typ;
        tag_in      = tag;
        out_ready   = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
        instr_in    = 'x;
        checkOutput({name, "_valid"}, 64'(out_valid_a), 64'd1);
        checkOutput({name, "_imm32"}, 64'(imm_a), 64'(exp32));
        checkOutput({name, "_type32"}, 64'(type_a), 64'(exp_type));
        checkOutput({name, "_ill32"}, 64'(illegal_a), 64'(exp_ill));
        checkOutput({name, "_tag32"}, 64'(tag_a), 64'(tag));
        checkOutput({name, "_imm64"}, imm_b, exp64);
        checkOutput({name, "_type64"}, 64'(type_b), 64'(exp_type));
        checkOutput({name, "_tag64"}, 64'(tag_b), 64'(tag));
        if (typ == 3'b110) begin
            checkOutput({name, "_noauto_imm"}, 64'(imm_c), 64'd0);
            checkOutput({name, "_noauto_type"}, 64'(type_c), 64'd7);
            checkOutput({name, "_noauto_ill"}, 64'(illegal_c), 64'd1);
        end else begin
            checkOutput({name, "_noauto_imm"}, 64'(imm_c), 64'(exp32));
            checkOutput({name, "_noauto_type"}, 64'(type_c), 64'(exp_type));
        end
        @(negedge clk);
        checkOutput({name, "_drained"}, 64'(out_valid_a), 64'd0);
        checkOutput({name, "_hold_imm"}, 64'(imm_a), 64'(exp32));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] rcv[$];
        int         sent;
        int         first_cyc;
        int         last_cyc;
        int         ready_drops;
        int         stray;

        rst         = 1'b1;
        in_valid    = 1'b0;
        instr_in    = '0;
        imm_type_in = '0;
        tag_in      = '0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid_a), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready_a), 64'd1);
        checkOutput("rst_imm", 64'(imm_a), 64'd0);
        checkOutput("rst_type", 64'(type_a), 64'd0);
        checkOutput("rst_ill", 64'(illegal_a), 64'd0);
        checkOutput("rst_tag", 64'(tag_a), 64'd0);
        rst = 1'b0;

        applyStimulus("i_addi",   32'hFFF00093, 3'b000, 8'h11, 32'hFFFFFFFF,
                      64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0);
        applyStimulus("s_sw",     32'hFE112E23, 3'b001, 8'h12, 32'hFFFFFFFC,
                      64'hFFFFFFFFFFFFFFFC, 3'b001, 1'b0);
        applyStimulus("b_fwd",    32'h00000463, 3'b010, 8'h13, 32'h00000008,
                      64'h0000000000000008, 3'b010, 1'b0);
        applyStimulus("csr_zimm", 32'h000F8073, 3'b101, 8'h14, 32'h0000001F,
                      64'h000000000000001F, 3'b101, 1'b0);
        applyStimulus("auto_lui", 32'h800000B7, 3'b110, 8'h15, 32'h80000000,
                      64'hFFFFFFFF80000000, 3'b011, 1'b0);
        applyStimulus("auto_bad", 32'h0000007F, 3'b110, 8'h16, 32'h0,
                      64'h0, 3'b111, 1'b1);
        applyStimulus("rsv_type", 32'hFFF00093, 3'b111, 8'h17, 32'h0,
                      64'h0, 3'b111, 1'b1);
        applyStimulus("auto_jal", 32'hFFDFF0EF, 3'b110, 8'h18, 32'hFFFFFFFC,
                      64'hFFFFFFFFFFFFFFFC, 3'b100, 1'b0);
        applyStimulus("auto_csri", 32'h000FD073, 3'b110, 8'h19, 32'h0000001F,
                      64'h000000000000001F, 3'b101, 1'b0);
        applyStimulus("auto_csrrw", 32'h340F9073, 3'b110, 8'h1A, 32'h00000340,
                      64'h0000000000000340, 3'b000, 1'b0);
        applyStimulus("auto_sw",  32'hFE112E23, 3'b110, 8'h1B, 32'hFFFFFFFC,
                      64'hFFFFFFFFFFFFFFFC, 3'b001, 1'b0);

        // Backpressure: tags 1..4 with out_ready low for three cycles; immediate equals tag.
        @(negedge clk);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        imm_type_in = 3'b000;
        tag_in      = 8'd1;
        instr_in    = {12'd1, 20'h00013};
        @(negedge clk);
        checkOutput("bp_ready_1", 64'(in_ready_a), 64'd1);
        checkOutput("bp_tag_1", 64'(tag_a), 64'd1);
        tag_in   = 8'd2;
        instr_in = {12'd2, 20'h00013};
        @(negedge clk);
        checkOutput("bp_ready_2", 64'(in_ready_a), 64'd0);
        checkOutput("bp_tag_2", 64'(tag_a), 64'd1);
        tag_in   = 8'd3;
        instr_in = {12'd3, 20'h00013};
        @(negedge clk);
        checkOutput("bp_ready_3", 64'(in_ready_a), 64'd0);
        checkOutput("bp_valid_3", 64'(out_valid_a), 64'd1);
        checkOutput("bp_tag_3", 64'(tag_a), 64'd1);
        checkOutput("bp_imm_3", 64'(imm_a), 64'd1);
        out_ready = 1'b1;
        sent = 2;
        rcv.delete();
        for (int cyc = 0; cyc < 20 && rcv.size() < 4; cyc++) begin
            if (out_valid_a && out_ready) rcv.push_back(tag_a);
            if (sent < 4) begin
                in_valid = 1'b1;
                tag_in   = 8'(sent + 1);
                instr_in = {12'(sent + 1), 20'h00013};
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready_a) sent++;
            @(negedge clk);
        end
        checkOutput("bp_count", 64'(rcv.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp_order_%0d", i),
                        (i < rcv.size()) ? 64'(rcv[i]) : 64'hFF, 64'(i + 1));
        end
        checkOutput("bp_empty", 64'(out_valid_a), 64'd0);

        // Throughput: sixteen back-to-back transfers with no bubbles.
        out_ready   = 1'b1;
        sent        = 0;
        first_cyc   = -1;
        last_cyc    = -1;
        ready_drops = 0;
        rcv.delete();
        for (int cyc = 0; cyc < 40 && rcv.size() < 16; cyc++) begin
            if (out_valid_a && out_ready) begin
                rcv.push_back(tag_a);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (!in_ready_a) ready_drops++;
            if (sent < 16) begin
                in_valid = 1'b1;
                tag_in   = 8'(8'd32 + 8'(sent));
                instr_in = {12'(sent), 20'h00013};
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready_a) sent++;
            @(negedge clk);
        end
        checkOutput("tp_count", 64'(rcv.size()), 64'd16);
        checkOutput("tp_first", 64'(first_cyc), 64'd1);
        checkOutput("tp_span", 64'(last_cyc - first_cyc), 64'd15);
        checkOutput("tp_ready_drops", 64'(ready_drops), 64'd0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("tp_order_%0d", i),
                        (i < rcv.size()) ? 64'(rcv[i]) : 64'hFF, 64'(32 + i));
        end

        // Reset with both registers full: everything in flight must vanish.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        tag_in      = 8'hA1;
        instr_in    = 32'h00100013;
        @(negedge clk);
        tag_in = 8'hA2;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rr_full_ready", 64'(in_ready_a), 64'd0);
        checkOutput("rr_full_valid", 64'(out_valid_a), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rr_valid_now", 64'(out_valid_a), 64'd0);
        checkOutput("rr_ready_now", 64'(in_ready_a), 64'd1);
        checkOutput("rr_tag_now", 64'(tag_a), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        stray     = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_a || tag_a == 8'hA1 || tag_a == 8'hA2) stray++;
        end
        checkOutput("rr_no_stray", 64'(stray), 64'd0);
        applyStimulus("rr_new", 32'h00500013, 3'b000, 8'hB3, 32'h00000005,
                      64'h0000000000000005, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
